// File: rtl/pdm_cic_decimator.sv
// rtl/pdm_cic_decimator.sv - 2nd-order CIC decimator turning a 1-bit PDM stream into signed PCM
//
// Purpose: integrates each enabled PDM bit (+1/-1) through two wrapping
// integrators, decimates by R = 2**LOG2R, runs a two-stage comb (D = 1) and
// presents the result through a one-entry valid/ready holding register.
// Gain is R**2, so full-scale output is +/-R**2.
//
// Ports:
//   mclk       in   microphone bit clock, all logic on posedge
//   reset      in   synchronous, active-high
//   pdm_bit    in   PDM data bit
//   pdm_en     in   pdm_bit is consumed only when high
//   pcm_data   out  W-bit signed PCM sample
//   pcm_valid  out  pcm_data holds an unconsumed sample
//   pcm_ready  in   consumer accepts pcm_data when pcm_valid is also high
//   overrun    out  sticky, a sample was dropped because the holding register was full
module pdm_cic_decimator #(
  parameter  int LOG2R = 6,
  localparam int W     = 2 * LOG2R + 2
) (
  input  logic                mclk,
  input  logic                reset,
  input  logic                pdm_bit,
  input  logic                pdm_en,
  output logic signed [W-1:0] pcm_data,
  output logic                pcm_valid,
  input  logic                pcm_ready,
  output logic                overrun
);

  // Integrator / decimation state
  logic signed [W-1:0] r_i1;
  logic signed [W-1:0] r_i2;
  logic [LOG2R-1:0]    r_phase;
  logic                r_dec_stb;
  logic signed [W-1:0] r_s0;

  // Comb state
  logic signed [W-1:0] r_d1;
  logic signed [W-1:0] r_d2;
  logic signed [W-1:0] r_y;
  logic                r_y_stb;
  logic [1:0]          r_warm;

  // Output holding register
  logic signed [W-1:0] r_pcm_data;
  logic                r_pcm_valid;
  logic                r_overrun;

  logic signed [W-1:0] w_x;
  logic signed [W-1:0] w_i2_next;
  logic                w_wrap;
  logic signed [W-1:0] w_c1;
  logic signed [W-1:0] w_y;
  logic                w_load;
  logic                w_accept;

  // 1 -> +1 (0...01), 0 -> -1 (1...11)
  assign w_x       = {{(W-1){~pdm_bit}}, 1'b1};
  // i2 accumulates the pre-update i1, so the post-update i2 is i2 + i1
  assign w_i2_next = r_i2 + r_i1;
  // R-th enabled bit of the window: phase counter is about to wrap
  assign w_wrap    = pdm_en && (&r_phase);

  assign w_c1      = r_s0 - r_d1;
  assign w_y       = w_c1 - r_d2;

  assign w_accept  = r_pcm_valid && pcm_ready;
  // Load when empty, or when the held sample leaves on this same edge
  assign w_load    = r_y_stb && (!r_pcm_valid || pcm_ready);

  // Integrators and phase counter; hold while pdm_en is low
  always_ff @(posedge mclk) begin
    if (reset) begin
      r_i1      <= '0;
      r_i2      <= '0;
      r_phase   <= '0;
      r_dec_stb <= 1'b0;
      r_s0      <= '0;
    end else begin
      r_dec_stb <= w_wrap;
      if (pdm_en) begin
        r_i1    <= r_i1 + w_x;
        r_i2    <= w_i2_next;
        r_phase <= r_phase + LOG2R'(1);
      end
      if (w_wrap) begin
        r_s0 <= w_i2_next;
      end
    end
  end

  // Comb stage; the first two outputs after reset are start-up transient
  always_ff @(posedge mclk) begin
    if (reset) begin
      r_d1    <= '0;
      r_d2    <= '0;
      r_y     <= '0;
      r_y_stb <= 1'b0;
      r_warm  <= '0;
    end else begin
      r_y_stb <= 1'b0;
      if (r_dec_stb) begin
        r_d1    <= r_s0;
        r_d2    <= w_c1;
        r_y     <= w_y;
        r_y_stb <= (r_warm == 2'd2);
        if (r_warm != 2'd2) begin
          r_warm <= r_warm + 2'd1;
        end
      end
    end
  end

  // One-entry output register with sticky overrun
  always_ff @(posedge mclk) begin
    if (reset) begin
      r_pcm_data  <= '0;
      r_pcm_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_load) begin
        r_pcm_data  <= r_y;
        r_pcm_valid <= 1'b1;
      end else if (w_accept) begin
        r_pcm_valid <= 1'b0;
      end
      if (r_y_stb && !w_load) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign pcm_data  = r_pcm_data;
  assign pcm_valid = r_pcm_valid;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_pdm_cic_decimator.sv
// tb/tb_pdm_cic_decimator.sv - scoreboard bench for pdm_cic_decimator
module tb_pdm_cic_decimator;

  localparam int LOG2R = 6;
  localparam int R     = 64;
  localparam int W     = 14;

  logic                mclk = 1'b0;
  logic                reset = 1'b1;
  logic                pdm_bit = 1'b0;
  logic                pdm_en = 1'b0;
  logic signed [W-1:0] pcm_data;
  logic                pcm_valid;
  logic                pcm_ready = 1'b1;
  logic                overrun;

  pdm_cic_decimator #(.LOG2R(LOG2R)) u_dut (
    .mclk      (mclk),
    .reset     (reset),
    .pdm_bit   (pdm_bit),
    .pdm_en    (pdm_en),
    .pcm_data  (pcm_data),
    .pcm_valid (pcm_valid),
    .pcm_ready (pcm_ready),
    .overrun   (overrun)
  );

  always #5 mclk = ~mclk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always @(posedge mclk) cyc <= cyc + 1;

  task automatic check(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic longint wrapw(input longint v);
    logic signed [W-1:0] t;
    t = v[W-1:0];
    return longint'(t);
  endfunction

  // Reference: after n bits, i2(n) = sum_j x_j*(n-1-j) = (n-1)*S0 - S1,
  // and each comb output is the second difference of i2 at window boundaries.
  longint sb[$];
  longint b_hist[$];
  longint s_sum0, s_sum1;
  longint n_in;
  bit     sb_on = 1'b1;
  bit     mon_on = 1'b1;
  bit     const_on = 1'b0;
  bit     mono_on = 1'b0;
  longint exp_const = 0;
  int     exp_gap = 0;

  task automatic model_clear();
    n_in = 0;
    s_sum0 = 0;
    s_sum1 = 0;
    b_hist.delete();
    b_hist.push_back(0);
    sb.delete();
  endtask

  task automatic drive_bit(input logic b, input logic en);
    longint x;
    longint bi2;
    int     k;
    pdm_bit = b;
    pdm_en  = en;
    if (en) begin
      x = b ? 64'sd1 : -64'sd1;
      s_sum0 += x;
      s_sum1 += n_in * x;
      n_in++;
      if (n_in % R == 0) begin
        bi2 = (n_in - 1) * s_sum0 - s_sum1;
        b_hist.push_back(bi2);
        k = b_hist.size() - 1;
        if (k >= 3 && sb_on)
          sb.push_back(wrapw(b_hist[k] - 2 * b_hist[k-1] + b_hist[k-2]));
      end
    end
    @(posedge mclk);
    #1;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    pdm_en  = 1'b0;
    pdm_bit = 1'b0;
    repeat (2) @(posedge mclk);
    #1;
    check("rst_valid", pcm_valid, 0);
    check("rst_data", pcm_data, 0);
    check("rst_overrun", overrun, 0);
    model_clear();
    reset = 1'b0;
  endtask

  task automatic flush_and_check(input string tag);
    for (int i = 0; i < 4; i++) drive_bit(1'b0, 1'b0);
    check(tag, sb.size(), 0);
  endtask

  // Output monitor: sampled at negedge, where inputs and outputs are settled
  longint got_v, exp_v, prev_v;
  bit     have_prev = 1'b0;
  int     last_acc = -1;

  always @(negedge mclk) begin
    if (reset) begin
      last_acc  = -1;
      have_prev = 1'b0;
    end else if (mon_on && pcm_valid && pcm_ready) begin
      got_v = longint'(pcm_data);
      if (sb.size() == 0) begin
        check("sb_underflow", 1, 0);
      end else begin
        exp_v = sb.pop_front();
        check("sb_data", got_v, exp_v);
      end
      if (const_on) check("steady_value", got_v, exp_const);
      if (mono_on && have_prev) check("ramp_increasing", (got_v > prev_v) ? 1 : 0, 1);
      prev_v    = got_v;
      have_prev = 1'b1;
      if (exp_gap > 0 && last_acc >= 0) check("sample_gap", cyc - last_acc, exp_gap);
      last_acc = cyc;
    end
  end

  int first;

  initial begin
    model_clear();

    // Constant ones: latency, value, spacing
    do_reset();
    const_on = 1'b1; exp_const = 4096; exp_gap = R;
    first = 0;
    for (int c = 1; c <= 7 * R; c++) begin
      drive_bit(1'b1, 1'b1);
      if (pcm_valid && first == 0) first = c;
    end
    check("first_valid_edge", first, 3 * R + 2);
    flush_and_check("ones_drain");

    // Constant zeros
    do_reset();
    exp_const = -4096;
    for (int c = 1; c <= 6 * R; c++) drive_bit(1'b0, 1'b1);
    flush_and_check("zeros_drain");

    // Alternating 1/0
    do_reset();
    exp_const = 0;
    for (int c = 1; c <= 6 * R; c++) drive_bit(c[0], 1'b1);
    flush_and_check("alt_drain");

    // 1110 repeated
    do_reset();
    exp_const = 2048;
    for (int c = 0; c < 6 * R; c++) drive_bit((c % 4) != 3, 1'b1);
    flush_and_check("p75_drain");

    // Duty ramp: window k starts with 8*k ones
    do_reset();
    const_on = 1'b0; mono_on = 1'b1;
    for (int k = 1; k <= 8; k++)
      for (int p = 0; p < R; p++) drive_bit(p < 8 * k, 1'b1);
    flush_and_check("ramp_drain");
    mono_on = 1'b0;

    // pdm_en every other cycle; disabled cycles carry 0 which must be ignored
    do_reset();
    const_on = 1'b1; exp_const = 4096; exp_gap = 2 * R;
    for (int c = 1; c <= 12 * R; c++) drive_bit(c[0], c[0]);
    flush_and_check("en_toggle_drain");

    // Backpressure: ready low for three sample periods
    do_reset();
    const_on = 1'b0; exp_gap = 0; mon_on = 1'b0; sb_on = 1'b0;
    pcm_ready = 1'b0;
    for (int c = 1; c <= 330; c++) begin
      drive_bit(c <= 3 * R, 1'b1);
      if (c == 3 * R + 2) begin
        check("hold_valid", pcm_valid, 1);
        check("hold_data_first", pcm_data, 4096);
      end
      if (c == 4 * R + 1) check("overrun_before", overrun, 0);
      if (c == 4 * R + 2) begin
        check("overrun_set", overrun, 1);
        check("hold_data_kept", pcm_data, 4096);
      end
    end
    check("hold_data_late", pcm_data, 4096);
    pcm_ready = 1'b1;
    drive_bit(1'b0, 1'b1);
    check("accepted_valid_low", pcm_valid, 0);
    for (int c = 0; c < 80; c++) drive_bit(1'b0, 1'b1);
    check("overrun_sticky", overrun, 1);
    do_reset();
    mon_on = 1'b1; sb_on = 1'b1;

    // Reset mid-window at cycle 100, then full restart
    const_on = 1'b1; exp_const = 4096; exp_gap = R;
    for (int c = 1; c <= 100; c++) drive_bit(1'b1, 1'b1);
    reset = 1'b1;
    @(posedge mclk);
    #1;
    check("midrst_valid", pcm_valid, 0);
    check("midrst_data", pcm_data, 0);
    check("midrst_overrun", overrun, 0);
    model_clear();
    reset = 1'b0;
    first = 0;
    for (int c = 1; c <= 5 * R; c++) begin
      drive_bit(1'b1, 1'b1);
      if (pcm_valid && first == 0) first = c;
    end
    check("midrst_first_valid", first, 3 * R + 2);
    flush_and_check("midrst_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pdm_cic_decimator.md
# pdm_cic_decimator

Converts the 1-bit PDM stream captured from the on-board MEMS microphone into signed PCM samples. It sits directly downstream of the microphone capture stage and runs in the same `mclk` domain. Each PDM bit is integrated through a 2nd-order CIC decimation filter. One PCM sample per `2**LOG2R` enabled input bits is presented on a valid/ready output port to the audio consumer (buffer or PWM playback).

## Interface
Parameters:
- `LOG2R`, default 6: log2 of the decimation ratio R (R = 64 at default); legal range 2..8.
- `W`, localparam = 2*LOG2R + 2 (14 at default): internal and output sample width.

Ports:
- `mclk`  in  1  microphone bit clock; all logic on posedge.
- `reset`  in  1  synchronous, active-high; clock `mclk`.
- `pdm_bit`  in  1  PDM data bit from the capture stage.
- `pdm_en`  in  1  qualifier; `pdm_bit` is consumed only on edges where this is high.
- `pcm_data`  out  W  signed two's-complement PCM sample.
- `pcm_valid`  out  1  `pcm_data` holds an unconsumed sample.
- `pcm_ready`  in  1  consumer accepts `pcm_data` on an edge with `pcm_valid` and `pcm_ready` both high.
- `overrun`  out  1  sticky; a sample was dropped because the holding register was full.

## Operation
- Input mapping: `pdm_bit`=1 maps to +1 and `pdm_bit`=0 maps to -1, sign-extended to W bits.
- Integrator stage, on each enabled edge: i1 <= i1 + x; i2 <= i2 + i1. Both are W-bit registers and wrap modulo 2**W; wrap is required for CIC correctness and is not an error.
- Phase counter: LOG2R bits, increments on each enabled edge. When it wraps from R-1 to 0, a registered decimation strobe `dec_stb` is set for one cycle, and the i2 value after that update is captured into `s0`.
- Comb stage, on the cycle `dec_stb` is high:
  - c1 = s0 - d1, then d1 <= s0.
  - y = c1 - d2, then d2 <= c1.
  - Differential delay is 1. All arithmetic is W bits and wraps.
- Gain is R**2. Steady-state full-scale output is +R**2 for all ones and -R**2 for all zeros (±4096 at default). Both fit in W bits signed.
- Warm-up: a 2-bit counter discards the first 2 comb outputs after reset; these are comb transient. The third and later outputs are delivered.
- Output holding register (one entry):
  - A delivered y is loaded into `pcm_data` and `pcm_valid` is set when the register is empty, or when it is being accepted on the same edge.
  - If the register is full and not being accepted, the new y is dropped, the held sample is kept, and `overrun` is set.
- `pcm_valid` clears on acceptance unless a new sample loads on the same edge.
- Reset clears i1, i2, s0, d1, d2, the phase counter, `dec_stb`, the warm-up counter, `pcm_data` (0), `pcm_valid` (0) and `overrun` (0).
- Reset mid-operation aborts any partial decimation window. The next window starts counting at the first enabled edge after reset deasserts.
- While `pdm_en` is low, the integrators and the phase counter hold. The comb stage and output port still operate.

## Timing
- Edge E: the R-th enabled bit of a window is integrated, and the phase counter wraps.
- Edge E+1: `dec_stb` is high and `s0` holds the captured value.
- Edge E+2: the comb result loads, and `pcm_valid` is high from edge E+2 onward. Latency from the last bit of a window to valid is 2 edges.
- Sample rate is one per R enabled edges. With continuous `pdm_en`, the minimum spacing between `pcm_valid` rising edges is R cycles.
- Acceptance and a new load on the same edge: the new sample replaces the old one, `pcm_valid` stays high, and no overrun is flagged.
- `pcm_data` is stable while `pcm_valid` is high and `pcm_ready` is low.
- `pcm_valid` never asserts before 3*R enabled edges plus 2 cycles after reset.

## Test plan
- Constant `pdm_bit`=1, `pdm_en`=1, `pcm_ready`=1 → first `pcm_valid` at edge 3*64+2 after reset, with `pcm_data`=+4096 (0x1000). Every later sample is +4096, spaced 64 cycles apart.
- Constant 0 → every delivered sample is -4096 (0x3000 in 14 bits). Alternating 1/0 → every delivered sample is 0.
- 75% ones pattern (1110 repeated) → steady-state samples are +2048. A ramp of duty cycle gives samples that increase monotonically.
- `pdm_en` toggling every other cycle with constant 1 → samples are still +4096, but spaced 128 cycles apart. Integrators do not change on disabled edges.
- `pcm_ready`=0 held for 3 sample periods → the first sample is held unchanged and `overrun`=1 after the second period. Raising `pcm_ready` accepts the held sample; `overrun` stays 1 until reset.
- Assert `reset` at cycle 100, mid-window → all outputs are 0 on the next edge. After release, the first valid appears again at 3*64+2 enabled edges and equals the expected steady-state value.
